// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file.
//   FULLW      : native datapath word width
//   WIDTH      : byte-lane width
//   REG_ADDR_W : default register address width
//   BYTE_LANES : byte lanes in a native word
package regfile_mp_pkg;

  localparam int unsigned FULLW      = 32;
  localparam int unsigned WIDTH      = 8;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned BYTE_LANES = FULLW / WIDTH;

endpackage

// File: rtl/regfile_rdport.sv
// One registered read port of the register file.
// Merges a same-cycle write into the array word (per byte lane), applies
// zero-register masking and owns the port's rdata/rbusy flops.
//   clk, reset (async active-low), en (0 holds outputs)
//   raddr, arr_word (array word at raddr), pend_bit (stored pending at raddr)
//   we, wa, wd, wbe (write port), pend_set, pend_addr (scoreboard set)
//   rdata, rbusy (registered outputs)
module regfile_rdport
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = FULLW,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [ADDR_W-1:0]     raddr,
  input  logic [DATA_W-1:0]     arr_word,
  input  logic                  pend_bit,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [DATA_W-1:0]     wd,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic                  pend_set,
  input  logic [ADDR_W-1:0]     pend_addr,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rbusy
);

  localparam int unsigned Lanes = DATA_W / WIDTH;

  logic              hit_wr, hit_set, is_zero;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              rbusy_d, rbusy_q;

  always_comb begin
    hit_wr  = we && (wa == raddr);
    hit_set = pend_set && (pend_addr == raddr);
    is_zero = ZERO_REG && (raddr == '0);
    rdata_d = arr_word;
    for (int i = 0; i < Lanes; i++) begin
      if (hit_wr && wbe[i]) rdata_d[i*WIDTH +: WIDTH] = wd[i*WIDTH +: WIDTH];
    end
    // Report pending as it will stand after this edge's clear/set.
    rbusy_d = (pend_bit && !hit_wr) || hit_set;
    if (is_zero) begin
      rdata_d = '0;
      rbusy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      rbusy_q <= 1'b0;
    end else if (en) begin
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign rdata = rdata_q;
  assign rbusy = rbusy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port general register file with byte-lane writes, write-to-read
// bypass and a per-register pending-write scoreboard.
//   clk, reset (async active-low), en (read-pipeline enable)
//   raddr/rdata/rbusy : NUM_RD packed read ports (1-cycle latency)
//   we, wa, wd, wbe   : write port with byte enables
//   pend_set/pend_addr: mark a register as awaiting writeback
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = FULLW,
  parameter int unsigned ADDR_W   = REG_ADDR_W,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [DATA_W/8-1:0]      wbe,
  input  logic                     pend_set,
  input  logic [ADDR_W-1:0]        pend_addr
);

  localparam int unsigned NumRegs = 1 << ADDR_W;
  localparam int unsigned Lanes   = DATA_W / WIDTH;

  if ((DATA_W % WIDTH) != 0 || DATA_W == 0) begin : g_bad_data_w
    $error("regfile_mp: DATA_W must be a non-zero multiple of 8");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be 1..4");
  end

  logic [DATA_W-1:0]  regs_q [NumRegs];
  logic [DATA_W-1:0]  regs_d [NumRegs];
  logic [NumRegs-1:0] pend_q, pend_d;

  always_comb begin
    regs_d = regs_q;
    if (we && !(ZERO_REG && (wa == '0))) begin
      for (int i = 0; i < Lanes; i++) begin
        if (wbe[i]) regs_d[wa][i*WIDTH +: WIDTH] = wd[i*WIDTH +: WIDTH];
      end
    end
    pend_d = pend_q;
    // Clear before set: a new issue in the same cycle as the old writeback wins.
    if (we)       pend_d[wa]        = 1'b0;
    if (pend_set) pend_d[pend_addr] = 1'b1;
    if (ZERO_REG) pend_d[0]         = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NumRegs; r++) regs_q[r] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = raddr[k*ADDR_W +: ADDR_W];

    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .raddr     (ra),
      .arr_word  (regs_q[ra]),
      .pend_bit  (pend_q[ra]),
      .we        (we),
      .wa        (wa),
      .wd        (wd),
      .wbe       (wbe),
      .pend_set  (pend_set),
      .pend_addr (pend_addr),
      .rdata     (rdata[k*DATA_W +: DATA_W]),
      .rbusy     (rbusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp. Two instances share stimulus: one with
// ZERO_REG=0 (plain) and one with ZERO_REG=1 (zero). Expected outputs are
// predicted when stimulus is driven, queued, and compared after the edge.
module tb_regfile_mp;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NR   = 2;
  localparam int NREG = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              en = 1'b0;
  logic              we = 1'b0;
  logic              pend_set = 1'b0;
  logic [NR*AW-1:0]  raddr = '0;
  logic [AW-1:0]     wa = '0;
  logic [AW-1:0]     pend_addr = '0;
  logic [DW-1:0]     wd = '0;
  logic [DW/8-1:0]   wbe = '0;
  logic [NR*DW-1:0]  rdata_p, rdata_z;
  logic [NR-1:0]     rbusy_p, rbusy_z;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b0)) u_dut_plain (
    .clk(clk), .reset(reset), .en(en), .raddr(raddr), .rdata(rdata_p), .rbusy(rbusy_p),
    .we(we), .wa(wa), .wd(wd), .wbe(wbe), .pend_set(pend_set), .pend_addr(pend_addr)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1)) u_dut_zero (
    .clk(clk), .reset(reset), .en(en), .raddr(raddr), .rdata(rdata_z), .rbusy(rbusy_z),
    .we(we), .wa(wa), .wd(wd), .wbe(wbe), .pend_set(pend_set), .pend_addr(pend_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR*DW-1:0] d;
    logic [NR-1:0]    b;
  } exp_t;

  exp_t          q_plain[$];
  exp_t          q_zero[$];
  logic [DW-1:0] m_regs [2][NREG];
  logic [NREG-1:0] m_pend [2];
  exp_t          m_hold [2];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int z = 0; z < 2; z++) begin
      for (int r = 0; r < NREG; r++) m_regs[z][r] = '0;
      m_pend[z] = '0;
      m_hold[z] = '0;
    end
  endtask

  // z=1 models the ZERO_REG instance.
  function automatic exp_t predict(input int z);
    exp_t          e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          hw, b;
    e = m_hold[z];
    if (en) begin
      for (int k = 0; k < NR; k++) begin
        a  = raddr[k*AW +: AW];
        d  = m_regs[z][a];
        hw = we && (wa == a);
        for (int i = 0; i < DW/8; i++) if (hw && wbe[i]) d[i*8 +: 8] = wd[i*8 +: 8];
        b = (m_pend[z][a] && !hw) || (pend_set && pend_addr == a);
        if (z == 1 && a == 0) begin
          d = '0;
          b = 1'b0;
        end
        e.d[k*DW +: DW] = d;
        e.b[k]          = b;
      end
    end
    return e;
  endfunction

  task automatic model_update(input int z);
    if (we && !(z == 1 && wa == 0)) begin
      for (int i = 0; i < DW/8; i++) if (wbe[i]) m_regs[z][wa][i*8 +: 8] = wd[i*8 +: 8];
    end
    if (we) m_pend[z][wa] = 1'b0;
    if (pend_set && !(z == 1 && pend_addr == 0)) m_pend[z][pend_addr] = 1'b1;
  endtask

  task automatic step(input logic e, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                      input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [3:0] be, input logic ps, input logic [AW-1:0] pa,
                      input string tag);
    exp_t ex;
    @(negedge clk);
    en = e; raddr = {r1, r0}; we = w; wa = a; wd = d; wbe = be; pend_set = ps; pend_addr = pa;
    ex = predict(0); q_plain.push_back(ex); m_hold[0] = ex; model_update(0);
    ex = predict(1); q_zero.push_back(ex);  m_hold[1] = ex; model_update(1);
    @(posedge clk);
    #1;
    check({tag, "_sb_plain"}, 64'(q_plain.size()), 64'd1);
    check({tag, "_sb_zero"}, 64'(q_zero.size()), 64'd1);
    ex = q_plain.pop_front();
    check({tag, "_rdata_plain"}, rdata_p, ex.d);
    check({tag, "_rbusy_plain"}, 64'(rbusy_p), 64'(ex.b));
    ex = q_zero.pop_front();
    check({tag, "_rdata_zero"}, rdata_z, ex.d);
    check({tag, "_rbusy_zero"}, 64'(rbusy_z), 64'(ex.b));
  endtask

  task automatic idle_inputs();
    we = 1'b0; pend_set = 1'b0; wbe = '0;
  endtask

  initial begin
    model_clear();
    #1;
    check("reset_rdata_plain", rdata_p, 64'd0);
    check("reset_rbusy_zero", 64'(rbusy_z), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: read every register on both ports after reset.
    for (int i = 0; i < NREG; i++) begin
      step(1'b1, 4'(i), 4'(NREG - 1 - i), 1'b0, '0, '0, 4'h0, 1'b0, '0, "t1_read");
    end

    // 2: full write then single-lane overwrite.
    step(1'b1, 4'd0, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, '0, "t2_wr_full");
    step(1'b1, 4'd0, 4'd0, 1'b1, 4'd3, 32'h000000AA, 4'h1, 1'b0, '0, "t2_wr_b0");
    step(1'b1, 4'd3, 4'd3, 1'b0, '0, '0, 4'h0, 1'b0, '0, "t2_read");
    check("t2_r3_const", 64'(rdata_p[31:0]), 64'hDEADBEAA);

    // Asynchronous reset mid-stream: outputs clear without a clock edge.
    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    check("t1_async_rdata_plain", rdata_p, 64'd0);
    check("t1_async_rdata_zero", rdata_z, 64'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 4'd3, 4'd3, 1'b0, '0, '0, 4'h0, 1'b0, '0, "t1_post_reset");

    // 3: same-cycle partial write bypass on port 0, port 1 unaffected.
    step(1'b1, 4'd0, 4'd0, 1'b1, 4'd5, 32'hAAAAAAAA, 4'hF, 1'b0, '0, "t3_init5");
    step(1'b1, 4'd0, 4'd0, 1'b1, 4'd6, 32'h66666666, 4'hF, 1'b0, '0, "t3_init6");
    step(1'b1, 4'd5, 4'd6, 1'b1, 4'd5, 32'h12345678, 4'hC, 1'b0, '0, "t3_bypass");
    check("t3_bypass_const", 64'(rdata_p[31:0]), 64'h1234AAAA);
    check("t3_port1_const", 64'(rdata_p[63:32]), 64'h66666666);

    // 4: scoreboard set, set-wins-over-clear, then clear.
    step(1'b1, 4'd7, 4'd7, 1'b0, '0, '0, 4'h0, 1'b1, 4'd7, "t4_set");
    step(1'b1, 4'd7, 4'd7, 1'b1, 4'd7, '0, 4'h0, 1'b1, 4'd7, "t4_set_wins");
    check("t4_set_wins_const", 64'(rbusy_p), 64'd3);
    step(1'b1, 4'd7, 4'd7, 1'b1, 4'd7, '0, 4'h0, 1'b0, '0, "t4_clear");
    step(1'b1, 4'd7, 4'd7, 1'b0, '0, '0, 4'h0, 1'b0, '0, "t4_read");
    check("t4_clear_const", 64'(rbusy_p), 64'd0);

    // 5: en=0 freezes outputs while state still updates.
    step(1'b1, 4'd3, 4'd5, 1'b0, '0, '0, 4'h0, 1'b1, 4'd9, "t5_prime");
    step(1'b0, 4'd2, 4'd1, 1'b1, 4'd2, 32'h00000055, 4'hF, 1'b0, '0, "t5_hold_a");
    step(1'b0, 4'd9, 4'd2, 1'b0, '0, '0, 4'h0, 1'b1, 4'd2, "t5_hold_b");
    step(1'b0, 4'd4, 4'd8, 1'b1, 4'd2, 32'h00000055, 4'h0, 1'b0, '0, "t5_hold_c");
    step(1'b1, 4'd2, 4'd9, 1'b0, '0, '0, 4'h0, 1'b0, '0, "t5_resume");
    check("t5_resume_const", 64'(rdata_p[31:0]), 64'h00000055);

    // 6: writes/pend to r0 with bypass; zero instance must read 0.
    step(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 4'd0, "t6_bypass");
    check("t6_bypass_zero_const", rdata_z, 64'd0);
    step(1'b1, 4'd0, 4'd0, 1'b0, '0, '0, 4'h0, 1'b0, '0, "t6_read");
    check("t6_read_zero_const", rdata_z, 64'd0);
    check("t6_read_plain_const", rdata_p, 64'hFFFFFFFF_FFFFFFFF);

    // Random mix.
    for (int n = 0; n < 60; n++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom),
           4'($urandom), $urandom, 4'($urandom), 1'($urandom), 4'($urandom), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
